hex_display_arbiter: RTL and testbench
======================================

// Module: hex_display_arbiter
// PURPOSE
//  Shares one seven-segment digit (e.g. HEX5) between NUM_REQ requesters, each offering a 4-bit value.
//  Round-robin arbitration; the winner's value is latched and shown, active-low, for HOLD_CYCLES cycles.
//  No other grant is issued during that window. Sits between lab datapaths and the board HEX outputs.
// PARAMETERS
//  NUM_REQ      2  number of requesters, >=2
//  HOLD_CYCLES  4  cycles a granted value is protected from re-arbitration, >=1
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  reset      in   1          asynchronous, active-high; clears all state immediately
//  req        in   NUM_REQ    level request per requester; held until its gnt bit is seen
//  data       in   4*NUM_REQ  requester i value on data[4*i+3:4*i]
//  gnt        out  NUM_REQ    registered one-hot, one-cycle pulse: value captured this edge
//  owner      out  clog2(NUM_REQ)  index of the last granted requester
//  busy       out  1          registered; high while in HOLD
//  hex        out  7          registered segment pattern {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset values (async, active-high):
//   - gnt=0, owner=0, busy=0, hex=7'b1111111 (blank)
//   - state=IDLE, hold count=0, round-robin pointer=0 (requester 0 has top priority)
//  States: IDLE, HOLD.
//  IDLE, at posedge with any req bit set:
//   - Winner w = first set req scanning from the pointer upward, wrapping NUM_REQ-1 -> 0.
//   - Same edge: gnt <= one-hot(w); owner <= w; hex <= seg(data[w]); cnt <= HOLD_CYCLES-1.
//   - Same edge: pointer <= (w+1) mod NUM_REQ; state <= HOLD; busy <= 1.
//  IDLE with req==0: gnt <= 0; everything else holds (hex keeps the last value).
//  HOLD, each posedge:
//   - gnt <= 0; req and data are ignored.
//   - cnt==0: state <= IDLE, busy <= 0. Otherwise cnt <= cnt-1.
//  Timing:
//   - Grant at edge N -> gnt high exactly one cycle; hex valid from edge N.
//   - busy high for HOLD_CYCLES cycles (edge N to edge N+HOLD_CYCLES).
//   - Earliest next grant at edge N+HOLD_CYCLES+1 -> max one grant per HOLD_CYCLES+1 cycles.
//  Sampling rules:
//   - req is sampled only at IDLE edges. A req dropped before that edge is never granted.
//   - gnt is never asserted to a requester whose req bit is 0 at the grant edge.
//   - Only data of the winner is captured; all other data lanes are don't-care.
//  Segment decode (all 16 codes): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//   5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011,
//   C=1000110, d=0100001, E=0000110, F=0001110.
//  Reset mid-HOLD or mid-grant: outputs go to reset values at once, with no clock needed.
//   After reset is released, arbitration restarts from requester 0.
//  Width rules: cnt is clog2(HOLD_CYCLES) bits, minimum 1; pointer wraps exactly at NUM_REQ.
// TESTING
//  1. Assert reset, no clock -> hex=1111111, gnt=0, busy=0, owner=0 immediately.
//  2. req=01, data0=4'h1 -> one-cycle gnt=01, hex=1111001, owner=0; busy high 4 cycles, then 0.
//  3. From reset, req=11, data0=2, data1=F held -> gnt=01 at edge N, hex=0100100;
//     then gnt=10 at edge N+5, hex=0001110.
//  4. req=11 held for 20 cycles -> grants alternate 01,10,01,10, spaced 5 cycles; never both bits set.
//  5. Grant to req0, then reset at HOLD cycle 2 -> immediate blank/idle.
//     After release with req=10 held -> gnt=10 on the first edge.
//  6. During HOLD pulse req0 for 1 cycle, then drop; change data1 -> no grant to req0, hex unchanged
//     until the next IDLE grant.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one active-low seven-segment digit between NUM_REQ requesters.
// The winner's value is latched and protected from re-arbitration for HOLD_CYCLES cycles.
module hex_display_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 4,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [4*NUM_REQ-1:0]   data_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [OW-1:0]          owner_o,
  output logic                   busy_o,
  output logic [6:0]             hex_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic [OW-1:0]      ptr_q;
  logic [CW-1:0]      cnt_q;

  logic               found_d;
  logic [OW-1:0]      win_d;
  logic [3:0]         win_data_d;
  logic [OW-1:0]      ptr_d;
  logic [NUM_REQ-1:0] gnt_d;

  // Segment pattern {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      4'hF:    seg7 = 7'b0001110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Winner search: first set request at or above the pointer, wrapping at NUM_REQ
  always_comb begin : pick
    logic [OW:0] idx_v;
    idx_v   = '0;
    found_d = 1'b0;
    win_d   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = {1'b0, ptr_q} + (OW+1)'(k);
      if (idx_v >= (OW+1)'(NUM_REQ)) begin
        idx_v = idx_v - (OW+1)'(NUM_REQ);
      end else begin
        idx_v = idx_v;
      end
      if (!found_d && req_i[idx_v[OW-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx_v[OW-1:0];
      end else begin
        found_d = found_d;
      end
    end
    win_data_d = data_i[{win_d, 2'b00} +: 4];
    gnt_d      = '0;
    gnt_d[win_d] = 1'b1;
    if (win_d == OW'(NUM_REQ-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_d + 1'b1;
    end
  end

  // Arbitration FSM with registered grant, owner, busy and segment outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_o   <= '0;
      owner_o <= '0;
      busy_o  <= 1'b0;
      hex_o   <= 7'b1111111;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gnt_o   <= gnt_d;
            owner_o <= win_d;
            hex_o   <= seg7(win_data_d);
            cnt_q   <= CW'(HOLD_CYCLES-1);
            ptr_q   <= ptr_d;
            state_q <= HOLD;
            busy_o  <= 1'b1;
          end else begin
            gnt_o <= '0;
          end
        end
        HOLD: begin
          gnt_o <= '0;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_o   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: expected grants are queued with the stimulus
// and checked by a negedge monitor; each scenario task also checks timing and busy inline.
module tb_hex_display_arbiter;

  typedef struct packed {
    logic [1:0] gnt;
    logic       owner;
    logic [6:0] hex;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] data = 8'h00;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic [6:0] hex;
  logic [1:0] req_at_edge = 2'b00;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  hex_display_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .data_i  (data),
    .gnt_o   (gnt),
    .owner_o (owner),
    .busy_o  (busy),
    .hex_o   (hex)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[v];
  endfunction

  function automatic exp_t mk(input logic [1:0] g, input logic o, input logic [3:0] v);
    exp_t e;
    e.gnt = g;
    e.owner = o;
    e.hex = exp_seg(v);
    return e;
  endfunction

  always @(posedge clk) req_at_edge <= req;

  // Scoreboard monitor: every grant pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (gnt !== 2'b00) begin
      exp_t e;
      total++;
      if ((gnt & ~req_at_edge) !== 2'b00) begin
        bad++; $display("FAIL gnt_without_req: gnt=%b req=%b", gnt, req_at_edge);
      end
      total++;
      if (gnt !== 2'b01 && gnt !== 2'b10) begin
        bad++; $display("FAIL gnt_onehot: gnt=%b", gnt);
      end
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_grant: gnt=%b owner=%0d hex=%b", gnt, owner, hex);
      end else begin
        e = sb_q.pop_front();
        total++;
        if (gnt !== e.gnt) begin
          bad++; $display("FAIL sb_gnt: got %b want %b", gnt, e.gnt);
        end
        total++;
        if (owner !== e.owner) begin
          bad++; $display("FAIL sb_owner: got %0d want %0d", owner, e.owner);
        end
        total++;
        if (hex !== e.hex) begin
          bad++; $display("FAIL sb_hex: got %b want %b", hex, e.hex);
        end
      end
    end
  end

  task automatic wait_gnt(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++; if (hex !== 7'b1111111) begin bad++; $display("FAIL reset_hex: got %b want 1111111", hex); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner: got %b want 0", owner); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int c;
    data = 8'h01;
    req = 2'b01;
    sb_q.push_back(mk(2'b01, 1'b0, 4'h1));
    wait_gnt(4, c);
    req = 2'b00;
    total++; if (c != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", c); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_edge0: got %b want 1", busy); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold%0d: got %b want 1", i, busy); end
      total++; if (hex !== exp_seg(4'h1)) begin bad++; $display("FAIL single_hex_hold%0d: got %b want %b", i, hex, exp_seg(4'h1)); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_requesters();
    int c1;
    int c2;
    do_reset();
    data = {4'hF, 4'h2};
    req = 2'b11;
    sb_q.push_back(mk(2'b01, 1'b0, 4'h2));
    sb_q.push_back(mk(2'b10, 1'b1, 4'hF));
    wait_gnt(4, c1);
    total++; if (c1 != 1) begin bad++; $display("FAIL two_first_latency: got %0d want 1", c1); end
    wait_gnt(10, c2);
    req = 2'b00;
    total++; if (c2 != 5) begin bad++; $display("FAIL two_spacing: got %0d want 5", c2); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_alternate();
    int last;
    int ngr;
    last = 0;
    ngr = 0;
    data = {4'h9, 4'h3};
    sb_q.push_back(mk(2'b01, 1'b0, 4'h3));
    sb_q.push_back(mk(2'b10, 1'b1, 4'h9));
    sb_q.push_back(mk(2'b01, 1'b0, 4'h3));
    sb_q.push_back(mk(2'b10, 1'b1, 4'h9));
    req = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        ngr++;
        total++;
        if (last == 0) begin
          if (i != 1) begin bad++; $display("FAIL alt_first_latency: got %0d want 1", i); end
        end else begin
          if (i - last != 5) begin bad++; $display("FAIL alt_spacing: got %0d want 5", i - last); end
        end
        last = i;
      end
    end
    req = 2'b00;
    total++; if (ngr != 4) begin bad++; $display("FAIL alt_grant_count: got %0d want 4", ngr); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    int c;
    data = {4'h0, 4'h7};
    req = 2'b01;
    sb_q.push_back(mk(2'b01, 1'b0, 4'h7));
    wait_gnt(4, c);
    req = 2'b00;
    total++; if (c != 1) begin bad++; $display("FAIL mid_latency: got %0d want 1", c); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (hex !== 7'b1111111) begin bad++; $display("FAIL mid_reset_hex: got %b want 1111111", hex); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL mid_reset_gnt: got %b want 00", gnt); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL mid_reset_owner: got %b want 0", owner); end
    data = {4'hA, 4'h7};
    req = 2'b10;
    sb_q.push_back(mk(2'b10, 1'b1, 4'hA));
    @(negedge clk);
    reset = 1'b0;
    wait_gnt(3, c);
    req = 2'b00;
    total++; if (c != 1) begin bad++; $display("FAIL mid_post_reset_latency: got %0d want 1", c); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_ignore_during_hold();
    int c;
    data = {4'h5, 4'h0};
    req = 2'b10;
    sb_q.push_back(mk(2'b10, 1'b1, 4'h5));
    wait_gnt(4, c);
    req = 2'b00;
    total++; if (c != 1) begin bad++; $display("FAIL ign_latency: got %0d want 1", c); end
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    data = {4'hC, 4'h0};
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++; if (hex !== exp_seg(4'h5)) begin bad++; $display("FAIL ign_hex_kept%0d: got %b want %b", i, hex, exp_seg(4'h5)); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle: busy got %b want 0", busy); end
    req = 2'b10;
    sb_q.push_back(mk(2'b10, 1'b1, 4'hC));
    wait_gnt(3, c);
    req = 2'b00;
    total++; if (c != 1) begin bad++; $display("FAIL ign_next_latency: got %0d want 1", c); end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_requesters();
    test_alternate();
    test_reset_mid_hold();
    test_ignore_during_hold();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
